// File: rtl/cpu6_regfile_wb_pkg.sv
// Shared widths and scoreboard-counter operation encoding for the cpu6 writeback register file.
package cpu6_regfile_wb_pkg;

    localparam int CPU6_RFIDX_WIDTH = 5;
    localparam int CPU6_XLEN        = 32;
    localparam int CPU6_SBCNT_WIDTH = 2;

    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_INC  = 2'd1,
        SB_DEC  = 2'd2,
        SB_CLR  = 2'd3
    } sbOp_e;

    // Flush wins over everything; a simultaneous issue and retire cancel out.
    function automatic sbOp_e sbDecode(input logic inc, input logic dec, input logic clr);
        if (clr)             return SB_CLR;
        else if (inc && !dec) return SB_INC;
        else if (dec && !inc) return SB_DEC;
        else                 return SB_HOLD;
    endfunction

endpackage

// File: rtl/cpu6_regfile_wb_if.sv
// Writeback, decode-read and scoreboard signals between the cpu6 pipeline and its register file.
interface cpu6_regfile_wb_if
    import cpu6_regfile_wb_pkg::*;
#(
    parameter int RFIDX_W = CPU6_RFIDX_WIDTH,
    parameter int XLEN    = CPU6_XLEN
) ();

    logic               regwriteW;
    logic [RFIDX_W-1:0] writeregW;
    logic [XLEN-1:0]    rdW;
    logic [RFIDX_W-1:0] ra1D;
    logic [RFIDX_W-1:0] ra2D;
    logic [XLEN-1:0]    rd1D;
    logic [XLEN-1:0]    rd2D;
    logic               issueD;
    logic [RFIDX_W-1:0] issuerdD;
    logic               sbclear;
    logic               busy1D;
    logic               busy2D;

    modport master (
        output regwriteW, writeregW, rdW, ra1D, ra2D, issueD, issuerdD, sbclear,
        input  rd1D, rd2D, busy1D, busy2D
    );

    modport slave (
        input  regwriteW, writeregW, rdW, ra1D, ra2D, issueD, issuerdD, sbclear,
        output rd1D, rd2D, busy1D, busy2D
    );

endinterface

// File: rtl/cpu6_rf_sbcnt.sv
// One pending-write counter of the register-file scoreboard: saturating up/down with flush.
module cpu6_rf_sbcnt
    import cpu6_regfile_wb_pkg::*;
#(
    parameter int SBCNT_W = CPU6_SBCNT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    input  logic               clr,
    output logic [SBCNT_W-1:0] cnt
);

    localparam logic [SBCNT_W-1:0] CNT_MAX = '1;

    sbOp_e op;
    assign op = sbDecode(inc, dec, clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            case (op)
                SB_CLR: cnt <= '0;
                SB_INC: begin
                    // More issues than E/M/W can hold means decode lost track.
                    assert (cnt != CNT_MAX);
                    if (cnt != CNT_MAX) cnt <= cnt + SBCNT_W'(1);
                end
                SB_DEC: begin
                    assert (cnt != '0);
                    if (cnt != '0) cnt <= cnt - SBCNT_W'(1);
                end
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cpu6_regfile_wb.sv
// cpu6 writeback register file: 2R/1W with write-through bypass, x0 hardwired to zero,
// and a per-register pending-write scoreboard feeding decode hazard detection.
module cpu6_regfile_wb
    import cpu6_regfile_wb_pkg::*;
#(
    parameter int RFIDX_W = CPU6_RFIDX_WIDTH,
    parameter int XLEN    = CPU6_XLEN,
    parameter int SBCNT_W = CPU6_SBCNT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    cpu6_regfile_wb_if.slave  rf
);

    localparam int NREG = 2 ** RFIDX_W;

    logic [XLEN-1:0]                  regs [NREG];
    logic [NREG-1:0][SBCNT_W-1:0]     cnt;
    logic [XLEN-1:0]                  rd1;
    logic [XLEN-1:0]                  rd2;

    function automatic logic isBusy(input logic [RFIDX_W-1:0] ra,
                                    input logic [SBCNT_W-1:0] c,
                                    input logic               wen,
                                    input logic [RFIDX_W-1:0] wa);
        // The last outstanding write landing this cycle is served by the bypass.
        return (ra != '0) && (c != '0) && !((c == SBCNT_W'(1)) && wen && (wa == ra));
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (rf.regwriteW && (rf.writeregW != '0)) begin
            regs[rf.writeregW] <= rf.rdW;
        end
    end

    assign cnt[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_sbcnt
        cpu6_rf_sbcnt #(.SBCNT_W(SBCNT_W)) u_sbcnt (
            .clk   (clk),
            .reset (reset),
            .inc   (rf.issueD && (rf.issuerdD == RFIDX_W'(i))),
            .dec   (rf.regwriteW && (rf.writeregW == RFIDX_W'(i))),
            .clr   (rf.sbclear),
            .cnt   (cnt[i])
        );
    end

    // Bypass is gated by reset so nothing written during reset is ever visible.
    always_comb begin
        rd1 = '0;
        if (reset && (rf.ra1D != '0)) begin
            if (rf.regwriteW && (rf.writeregW == rf.ra1D)) rd1 = rf.rdW;
            else                                          rd1 = regs[rf.ra1D];
        end
    end

    always_comb begin
        rd2 = '0;
        if (reset && (rf.ra2D != '0)) begin
            if (rf.regwriteW && (rf.writeregW == rf.ra2D)) rd2 = rf.rdW;
            else                                          rd2 = regs[rf.ra2D];
        end
    end

    assign rf.rd1D   = rd1;
    assign rf.rd2D   = rd2;
    assign rf.busy1D = isBusy(rf.ra1D, cnt[rf.ra1D], rf.regwriteW, rf.writeregW);
    assign rf.busy2D = isBusy(rf.ra2D, cnt[rf.ra2D], rf.regwriteW, rf.writeregW);

endmodule

// File: tb/tb_cpu6_regfile_wb.sv
// Directed bench for cpu6_regfile_wb: reset, write/read, bypass, x0, scoreboard, flush and reset.
module tb_cpu6_regfile_wb;

    logic clk;
    logic reset;
    int   nPass;
    int   nChk;

    cpu6_regfile_wb_if rf ();

    cpu6_regfile_wb dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.regwriteW = 1'b0;
        rf.writeregW = '0;
        rf.rdW       = '0;
        rf.issueD    = 1'b0;
        rf.issuerdD  = '0;
        rf.sbclear   = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] ra;
        for (int k = 0; k < 4; k++) begin
            ra = 5'($urandom_range(1, 31));
            rf.ra1D = ra;
            rf.ra2D = 5'($urandom_range(0, 31));
            rf.regwriteW = 1'b1; rf.writeregW = ra; rf.rdW = $urandom;
            rf.issueD = 1'b1; rf.issuerdD = ra;
            #1;
            nChk++; if (rf.rd1D !== 32'h0) $display("FAIL rst_rd1: got %h want %h", rf.rd1D, 32'h0); else nPass++;
            nChk++; if (rf.rd2D !== 32'h0) $display("FAIL rst_rd2: got %h want %h", rf.rd2D, 32'h0); else nPass++;
            nChk++; if ({rf.busy1D, rf.busy2D} !== 2'b00) $display("FAIL rst_busy: got %b want %b", {rf.busy1D, rf.busy2D}, 2'b00); else nPass++;
            tick();
        end
        idle();
        rf.ra1D = ra;
        reset = 1'b1;
        #1;
        nChk++; if (rf.rd1D !== 32'h0) $display("FAIL rst_ignored_wr: got %h want %h", rf.rd1D, 32'h0); else nPass++;
        nChk++; if (rf.busy1D !== 1'b0) $display("FAIL rst_ignored_issue: got %b want %b", rf.busy1D, 1'b0); else nPass++;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        rf.issueD = 1'b1; rf.issuerdD = 5'd5;
        tick();
        idle();
        rf.ra1D = 5'd5; rf.ra2D = 5'd0;
        #1;
        nChk++; if (rf.busy1D !== 1'b1) $display("FAIL wr_pending: got %b want %b", rf.busy1D, 1'b1); else nPass++;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd5; rf.rdW = 32'hDEADBEEF;
        #1;
        nChk++; if (rf.busy1D !== 1'b0) $display("FAIL wr_landing_busy: got %b want %b", rf.busy1D, 1'b0); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.rd1D !== 32'hDEADBEEF) $display("FAIL wr_rd1: got %h want %h", rf.rd1D, 32'hDEADBEEF); else nPass++;
        nChk++; if (rf.rd2D !== 32'h0) $display("FAIL wr_rd2_x0: got %h want %h", rf.rd2D, 32'h0); else nPass++;
    endtask

    task automatic test_bypass();
        idle();
        rf.issueD = 1'b1; rf.issuerdD = 5'd7;
        tick();
        idle();
        rf.ra1D = 5'd7; rf.ra2D = 5'd7;
        #1;
        nChk++; if (rf.rd1D !== 32'h0) $display("FAIL byp_before: got %h want %h", rf.rd1D, 32'h0); else nPass++;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd7; rf.rdW = 32'h0000_1234;
        #1;
        nChk++; if (rf.rd1D !== 32'h0000_1234) $display("FAIL byp_rd1: got %h want %h", rf.rd1D, 32'h0000_1234); else nPass++;
        nChk++; if (rf.rd2D !== 32'h0000_1234) $display("FAIL byp_rd2: got %h want %h", rf.rd2D, 32'h0000_1234); else nPass++;
        nChk++; if ({rf.busy1D, rf.busy2D} !== 2'b00) $display("FAIL byp_busy: got %b want %b", {rf.busy1D, rf.busy2D}, 2'b00); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.rd2D !== 32'h0000_1234) $display("FAIL byp_commit: got %h want %h", rf.rd2D, 32'h0000_1234); else nPass++;
    endtask

    task automatic test_x0();
        idle();
        rf.regwriteW = 1'b1; rf.writeregW = 5'd0; rf.rdW = 32'hFFFF_FFFF;
        rf.issueD = 1'b1; rf.issuerdD = 5'd0;
        rf.ra1D = 5'd0; rf.ra2D = 5'd0;
        #1;
        nChk++; if (rf.rd1D !== 32'h0) $display("FAIL x0_byp: got %h want %h", rf.rd1D, 32'h0); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.rd2D !== 32'h0) $display("FAIL x0_rd: got %h want %h", rf.rd2D, 32'h0); else nPass++;
        nChk++; if ({rf.busy1D, rf.busy2D} !== 2'b00) $display("FAIL x0_busy: got %b want %b", {rf.busy1D, rf.busy2D}, 2'b00); else nPass++;
        rf.ra1D = 5'd5;
        #1;
        nChk++; if (rf.rd1D !== 32'hDEADBEEF) $display("FAIL x0_other: got %h want %h", rf.rd1D, 32'hDEADBEEF); else nPass++;
    endtask

    task automatic test_scoreboard();
        idle();
        rf.ra1D = 5'd3; rf.ra2D = 5'd3;
        rf.issueD = 1'b1; rf.issuerdD = 5'd3;
        tick();
        tick();
        idle();
        #1;
        nChk++; if (rf.busy1D !== 1'b1) $display("FAIL sb_cnt2: got %b want %b", rf.busy1D, 1'b1); else nPass++;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd3; rf.rdW = 32'h0000_00A1;
        #1;
        nChk++; if (rf.busy2D !== 1'b1) $display("FAIL sb_cnt2_landing: got %b want %b", rf.busy2D, 1'b1); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.busy1D !== 1'b1) $display("FAIL sb_cnt1: got %b want %b", rf.busy1D, 1'b1); else nPass++;
        nChk++; if (rf.rd1D !== 32'h0000_00A1) $display("FAIL sb_rd_a1: got %h want %h", rf.rd1D, 32'h0000_00A1); else nPass++;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd3; rf.rdW = 32'h0000_00B2;
        #1;
        nChk++; if (rf.busy1D !== 1'b0) $display("FAIL sb_last_landing: got %b want %b", rf.busy1D, 1'b0); else nPass++;
        nChk++; if (rf.rd1D !== 32'h0000_00B2) $display("FAIL sb_last_byp: got %h want %h", rf.rd1D, 32'h0000_00B2); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.busy2D !== 1'b0) $display("FAIL sb_drained: got %b want %b", rf.busy2D, 1'b0); else nPass++;
        rf.issueD = 1'b1; rf.issuerdD = 5'd3;
        tick();
        rf.regwriteW = 1'b1; rf.writeregW = 5'd3; rf.rdW = 32'h0000_00C3;
        #1;
        nChk++; if (rf.busy1D !== 1'b0) $display("FAIL sb_issue_ignored: got %b want %b", rf.busy1D, 1'b0); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.busy1D !== 1'b1) $display("FAIL sb_inc_dec_hold: got %b want %b", rf.busy1D, 1'b1); else nPass++;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd3; rf.rdW = 32'h0000_00D4;
        tick();
        idle();
        #1;
        nChk++; if ({rf.busy1D, rf.rd1D} !== {1'b0, 32'h0000_00D4}) $display("FAIL sb_final: got %b/%h want %b/%h", rf.busy1D, rf.rd1D, 1'b0, 32'h0000_00D4); else nPass++;
    endtask

    task automatic test_back_to_back();
        idle();
        rf.issueD = 1'b1; rf.issuerdD = 5'd10;
        tick();
        rf.issuerdD = 5'd11;
        tick();
        idle();
        rf.ra1D = 5'd10; rf.ra2D = 5'd11;
        #1;
        nChk++; if ({rf.busy1D, rf.busy2D} !== 2'b11) $display("FAIL b2b_busy: got %b want %b", {rf.busy1D, rf.busy2D}, 2'b11); else nPass++;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd10; rf.rdW = 32'h1010_1010;
        tick();
        rf.writeregW = 5'd11; rf.rdW = 32'h1111_1111;
        #1;
        nChk++; if ({rf.busy1D, rf.busy2D} !== 2'b00) $display("FAIL b2b_landing: got %b want %b", {rf.busy1D, rf.busy2D}, 2'b00); else nPass++;
        tick();
        idle();
        #1;
        nChk++; if (rf.rd1D !== 32'h1010_1010) $display("FAIL b2b_rd1: got %h want %h", rf.rd1D, 32'h1010_1010); else nPass++;
        nChk++; if (rf.rd2D !== 32'h1111_1111) $display("FAIL b2b_rd2: got %h want %h", rf.rd2D, 32'h1111_1111); else nPass++;
    endtask

    task automatic test_flush_reset();
        idle();
        rf.ra1D = 5'd4; rf.ra2D = 5'd5;
        rf.issueD = 1'b1; rf.issuerdD = 5'd4;
        tick();
        tick();
        idle();
        #1;
        nChk++; if (rf.busy1D !== 1'b1) $display("FAIL fl_cnt2: got %b want %b", rf.busy1D, 1'b1); else nPass++;
        rf.sbclear = 1'b1;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd4; rf.rdW = 32'h0000_55AA;
        tick();
        idle();
        #1;
        nChk++; if (rf.busy1D !== 1'b0) $display("FAIL fl_busy: got %b want %b", rf.busy1D, 1'b0); else nPass++;
        nChk++; if (rf.rd1D !== 32'h0000_55AA) $display("FAIL fl_commit: got %h want %h", rf.rd1D, 32'h0000_55AA); else nPass++;
        rf.issueD = 1'b1; rf.issuerdD = 5'd4;
        tick();
        idle();
        reset = 1'b0;
        rf.regwriteW = 1'b1; rf.writeregW = 5'd4; rf.rdW = 32'h1111_2222;
        #1;
        nChk++; if ({rf.rd1D, rf.rd2D} !== 64'h0) $display("FAIL mr_lost: got %h/%h want 0/0", rf.rd1D, rf.rd2D); else nPass++;
        tick();
        idle();
        reset = 1'b1;
        #1;
        nChk++; if (rf.rd1D !== 32'h0) $display("FAIL mr_no_write: got %h want %h", rf.rd1D, 32'h0); else nPass++;
        nChk++; if (rf.busy1D !== 1'b0) $display("FAIL mr_cnt: got %b want %b", rf.busy1D, 1'b0); else nPass++;
    endtask

    initial begin
        nPass = 0;
        nChk  = 0;
        reset = 1'b0;
        idle();
        rf.ra1D = '0;
        rf.ra2D = '0;
        #1;
        test_reset();
        test_write_read();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_back_to_back();
        test_flush_reset();
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
